// File: rtl/button_debounce_if.sv
// ---------------------------------------------------------------------------
// button_debounce_if
//   Groups the push-button pin and the conditioned outputs of button_debounce.
//   The slave modport belongs to the debouncer; the master modport belongs to
//   whatever owns the pin and consumes the pulses.
//
//   btn_raw      asynchronous, bouncing button pin (into the debouncer)
//   btn_level    debounced level, 1 = pressed
//   btn_press    one-cycle pulse on an accepted press
//   btn_release  one-cycle pulse on an accepted release
//   btn_long     one-cycle pulse after a long hold (0 when the feature is off)
// ---------------------------------------------------------------------------
interface button_debounce_if;
  logic btn_raw;
  logic btn_level;
  logic btn_press;
  logic btn_release;
  logic btn_long;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_long
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_long
  );
endinterface

// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
//   Conditions a raw mechanical push-button before it reaches the LED
//   sequencer. The pin is polarity-corrected, passed through a two-flop
//   synchroniser and then debounced by a four-state FSM. Produces a clean
//   level plus single-cycle press/release pulses; btn_press feeds the
//   sequencer's start input, btn_level is for status use.
//
//   Optional feature macro: LONG_PRESS_EN
//     defined   -> a hold counter runs while the button is accepted as
//                  pressed and btn_long pulses once after LONG_CYCLES.
//     undefined -> no hold counter, btn_long is tied to 0.
//
//   Parameters
//     DEBOUNCE_CYCLES  cycles the input must be stable to accept a change (>=1)
//     LONG_CYCLES      hold cycles before btn_long fires (>=1)
//     BTN_ACTIVE_HIGH  1: pin high = pressed, 0: pin low = pressed
//
//   Ports
//     clk     system clock, all logic on posedge
//     rst     synchronous active-high reset
//     btn_if  button_debounce_if.slave (btn_raw in; level/press/release/long out)
// ---------------------------------------------------------------------------
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter int unsigned LONG_CYCLES     = 100_000_000,
  parameter bit          BTN_ACTIVE_HIGH = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  button_debounce_if.slave  btn_if
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  // Reject parameter values for which the counters make no sense.
  if (DEBOUNCE_CYCLES == 0) begin : g_bad_debounce
    $error("button_debounce: DEBOUNCE_CYCLES must be at least 1");
  end
  if (LONG_CYCLES == 0) begin : g_bad_long
    $error("button_debounce: LONG_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  logic          pressed_raw;
  logic          s1_q, s2_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  // Normalise polarity before the synchroniser so everything downstream
  // treats 1 as pressed.
  assign pressed_raw = BTN_ACTIVE_HIGH ? btn_if.btn_raw : ~btn_if.btn_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= pressed_raw;
      s2_q <= s1_q;
    end
  end

  // FSM and debounce counter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Next state. Both wait states count DEBOUNCE_CYCLES further stable
  // samples after the one that left the stable state; any opposite sample
  // falls straight back without a pulse. Pulses are decided here from the
  // transition so that the registered outputs line up with the new state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s2_q) begin
          state_d = IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d = PRESSED;
          press_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!s2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s2_q) begin
          state_d = PRESSED;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  assign btn_if.btn_level   = level_q;
  assign btn_if.btn_press   = press_q;
  assign btn_if.btn_release = release_q;

`ifdef LONG_PRESS_EN
  localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_TARGET = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(LONG_CYCLES - 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          long_q, long_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  // The hold count restarts only on a fresh accepted press, so a release
  // bounce keeps accumulating. Saturating at the target makes the pulse
  // fire at most once per press.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if ((state_q == PRESS_WAIT) && (state_d == PRESSED)) begin
      hold_d = '0;
    end else if ((state_q == PRESSED) || (state_q == RELEASE_WAIT)) begin
      if (hold_q != HOLD_TARGET) begin
        hold_d = hold_q + 1'b1;
        long_d = (hold_q == HOLD_LAST);
      end
    end
  end

  assign btn_if.btn_long = long_q;
`else
  assign btn_if.btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// ---------------------------------------------------------------------------
// tb_button_debounce
//   Drives two debouncers from the same logical button: one active-high and
//   one active-low (pin inverted). Both must produce identical outputs.
//   The reference model works on the idea of "a value seen on D+1
//   consecutive synchronised samples becomes the accepted level", with the
//   synchroniser treated as a two-sample delay line.
// ---------------------------------------------------------------------------
module tb_button_debounce;

  localparam int unsigned DEB   = 4;
  localparam int unsigned LONGC = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  button_debounce_if ifH ();
  button_debounce_if ifL ();

  button_debounce #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONGC),
    .BTN_ACTIVE_HIGH (1'b1)
  ) dutH (
    .clk    (clk),
    .rst    (rst),
    .btn_if (ifH)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONGC),
    .BTN_ACTIVE_HIGH (1'b0)
  ) dutL (
    .clk    (clk),
    .rst    (rst),
    .btn_if (ifL)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  bit d1, d2;
  bit runVal;
  int runLen;
  bit level;
  int hold;
  bit expPress, expRelease, expLong;

  // observation bookkeeping
  int tickNo = 0;
  int pressCount, releaseCount, longCount;
  int lastPressTick, lastReleaseTick;
`ifdef LONG_PRESS_EN
  int lastLongTick;
`endif

  task automatic compareBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s tick %0d observed %b expected %b", tag, tickNo, obs, exp);
    end
  endtask

  task automatic compareInt(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge of the abstract model.
  function automatic void updateModel(input bit r, input bit pressedRaw);
    bit x;
    bit prevLevel;
    if (r) begin
      d1 = 0; d2 = 0; runVal = 0; runLen = 0; level = 0; hold = 0;
      expPress = 0; expRelease = 0; expLong = 0;
      return;
    end
    x  = d2;
    d2 = d1;
    d1 = pressedRaw;
    if (runLen > 0 && x == runVal) runLen++;
    else begin
      runVal = x;
      runLen = 1;
    end
    prevLevel = level;
    if (x != level && runLen >= int'(DEB) + 1) level = x;
    expPress   = !prevLevel && level;
    expRelease = prevLevel && !level;
    expLong    = 0;
    if (prevLevel && hold < int'(LONGC)) begin
      hold++;
`ifdef LONG_PRESS_EN
      expLong = (hold == int'(LONGC));
`endif
    end
    if (expPress) hold = 0;
  endfunction

  task automatic checkOutput();
    compareBit("levelH",   ifH.btn_level,   level);
    compareBit("pressH",   ifH.btn_press,   expPress);
    compareBit("releaseH", ifH.btn_release, expRelease);
    compareBit("longH",    ifH.btn_long,    expLong);
    compareBit("levelL",   ifL.btn_level,   level);
    compareBit("pressL",   ifL.btn_press,   expPress);
    compareBit("releaseL", ifL.btn_release, expRelease);
    compareBit("longL",    ifL.btn_long,    expLong);
  endtask

  // Drive at the falling edge, let the rising edge sample, check 1 ns later.
  task automatic applyStimulus(input bit r, input bit pressedRaw);
    @(negedge clk);
    rst         = r;
    ifH.btn_raw = pressedRaw;
    ifL.btn_raw = ~pressedRaw;
    @(posedge clk);
    tickNo++;
    updateModel(r, pressedRaw);
    #1;
    checkOutput();
    if (ifH.btn_press)   begin pressCount++;   lastPressTick   = tickNo; end
    if (ifH.btn_release) begin releaseCount++; lastReleaseTick = tickNo; end
    if (ifH.btn_long) begin
      longCount++;
`ifdef LONG_PRESS_EN
      lastLongTick = tickNo;
`endif
    end
  endtask

  task automatic clearCounts();
    pressCount = 0; releaseCount = 0; longCount = 0;
    lastPressTick = -100; lastReleaseTick = -100;
`ifdef LONG_PRESS_EN
    lastLongTick = -100;
`endif
  endtask

  int startTick;
  int expLongCount;

  initial begin
    ifH.btn_raw = 1'b0;
    ifL.btn_raw = 1'b1;
`ifdef LONG_PRESS_EN
    expLongCount = 1;
`else
    expLongCount = 0;
`endif
    clearCounts();

    // Button held through reset: re-debounced, one press 6 cycles after release of reset.
    repeat (3) applyStimulus(1'b1, 1'b1);
    clearCounts();
    startTick = tickNo + 1;
    repeat (9) applyStimulus(1'b0, 1'b1);
    compareInt("rstHeldPressCount", pressCount, 1);
    compareInt("rstHeldPressLatency", lastPressTick - startTick, 6);
    compareBit("rstHeldLevel", ifH.btn_level, 1'b1);
    repeat (10) applyStimulus(1'b0, 1'b0);

    // Short 3-cycle pulse must be rejected.
    clearCounts();
    repeat (3) applyStimulus(1'b0, 1'b1);
    repeat (8) applyStimulus(1'b0, 1'b0);
    compareInt("shortPulsePress", pressCount, 0);
    compareInt("shortPulseRelease", releaseCount, 0);

    // Clean press and release latency.
    clearCounts();
    startTick = tickNo + 1;
    repeat (8) applyStimulus(1'b0, 1'b1);
    compareInt("pressLatency", lastPressTick - startTick, 6);
    startTick = tickNo + 1;
    repeat (8) applyStimulus(1'b0, 1'b0);
    compareInt("releaseLatency", lastReleaseTick - startTick, 6);
    compareInt("releaseCount", releaseCount, 1);
    compareBit("levelAfterRelease", ifH.btn_level, 1'b0);

    // Long hold with a 2-cycle release glitch.
    clearCounts();
    repeat (8) applyStimulus(1'b0, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b0);
    repeat (25) applyStimulus(1'b0, 1'b1);
    compareInt("glitchPressCount", pressCount, 1);
    compareInt("glitchReleaseCount", releaseCount, 0);
    compareBit("glitchLevel", ifH.btn_level, 1'b1);
    compareInt("longCount", longCount, expLongCount);
`ifdef LONG_PRESS_EN
    compareInt("longLatency", lastLongTick - lastPressTick, 10);
`endif
    repeat (10) applyStimulus(1'b0, 1'b0);

    // Reset while a press is pending drops it; held button is re-accepted once.
    clearCounts();
    repeat (5) applyStimulus(1'b0, 1'b1);
    repeat (2) applyStimulus(1'b1, 1'b1);
    repeat (10) applyStimulus(1'b0, 1'b1);
    compareInt("midResetPressCount", pressCount, 1);
    repeat (10) applyStimulus(1'b0, 1'b0);

    // Random bouncing runs with occasional resets, checked every cycle by the model.
    for (int i = 0; i < 80; i++) begin
      bit v;
      int len;
      bit doRst;
      v     = 1'($urandom_range(0, 1));
      len   = int'($urandom_range(1, 9));
      doRst = ($urandom_range(0, 29) == 0);
      for (int j = 0; j < len; j++) applyStimulus(doRst && (j == 0), v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
